writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage downstream of the execute stage. Accepts {opcode, operand, rd, result, N, Z}
//   over a valid/ready handshake and retires it: register-file write, flag register update, PC redirect.
//   Owns the architectural N/Z flags, squashes wrong-path instructions after a taken branch, and halts the core.
// PARAMETERS
//   DATA_W        16  datapath width (result, rf_wdata)
//   PC_W          12  program-counter / operand width
//   RF_AW          4  register-file address width
//   FLUSH_CYCLES   2  wrong-path cycles squashed after a taken redirect (0 = no squash)
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   ex_valid     in   1       execute-stage output valid
//   ex_ready     out  1       stage can accept (combinational: state != HALT)
//   ex_opcode    in   4       instruction opcode
//   ex_operand   in   PC_W    instruction operand (branch target source)
//   ex_rd        in   RF_AW   destination register index
//   ex_result    in   DATA_W  execute-stage result
//   ex_n, ex_z   in   1 each  execute-stage flags
//   rf_we        out  1       register-file write enable (1-cycle pulse)
//   rf_waddr     out  RF_AW   write address
//   rf_wdata     out  DATA_W  write data
//   pc_load      out  1       PC redirect pulse
//   pc_target    out  PC_W    redirect target
//   flag_n       out  1       architectural N flag
//   flag_z       out  1       architectural Z flag
//   halted       out  1       core halted
//   retired_cnt  out  16      committed-instruction counter
// BEHAVIOUR
//   Reset: all outputs 0, state RUN, flush counter 0. Reset mid-FLUSH or in HALT returns to RUN.
//   Accept = ex_valid & ex_ready. All outputs registered: effects appear the cycle after accept (latency 1).
//   Opcode classes: 0000 LOAD; 0001-0110 ALU; 0111 JMP; 1000 BRN; 1001 BRZ; 1010-1110 NOP; 1111 HALT.
//   Commit (RUN state, accept):
//     LOAD, ALU: rf_we=1, rf_waddr=ex_rd, rf_wdata=ex_result. Other classes: rf_we=0.
//     ALU only: flag_n<=ex_n, flag_z<=ex_z. LOAD/branches/NOP/HALT leave flags unchanged.
//     JMP: pc_load=1, pc_target=ex_operand. BRN/BRZ: taken iff flag_n / flag_z (register value
//       before this commit) is 1; taken -> pc_load=1, pc_target=ex_operand; not taken -> no-op.
//     HALT: halted<=1, state->HALT.
//     retired_cnt increments (wraps 0xFFFF->0) on every commit, including not-taken branches, NOP, HALT.
//   rf_we and pc_load are single-cycle pulses; idle cycles drive them 0, data outputs hold.
//   States:
//     RUN:   taken redirect with FLUSH_CYCLES>0 -> FLUSH, counter<=FLUSH_CYCLES; HALT -> HALT.
//     FLUSH: ex_ready=1; accepted instructions discarded (no write, no flags, no redirect,
//            no count, HALT ignored). Counter decrements every cycle; counter==1 -> RUN.
//     HALT:  ex_ready=0, halted=1; exits only on reset.
//   Back-to-back: ALU then BRZ on consecutive cycles -> BRZ sees the ALU's Z (flags commit at accept edge).
//   ex_* inputs are ignored when not accepted; no X propagates to outputs.
// STRUCTURE
//   Shared package wb_pkg: opcode localparams (OP_LOAD..OP_HALT), state enum {RUN, FLUSH, HALT},
//   is_alu/is_write helper functions. Reused by the decode and execute stages.
//   One sub-module: wb_flush_ctr (load/decrement/done counter, width $clog2(FLUSH_CYCLES+1)).
// TESTING
//   1. Reset held, then released: all outputs 0, ex_ready=1, state RUN.
//   2. LOAD rd=3 result=0x0ABC -> next cycle rf_we=1, waddr=3, wdata=0x0ABC; flags unchanged; retired_cnt=1.
//   3. ALU result=0 z=1 then BRZ operand=0x040 back-to-back -> pc_load=1, target=0x040;
//      next 2 valid ALU instrs discarded (rf_we=0, flags hold); third commits.
//   4. BRN with flag_n=0 -> pc_load=0, no FLUSH, retired_cnt+1; JMP operand=0xFFF -> pc_target=0xFFF.
//   5. HALT -> halted=1, ex_ready=0 next cycle; further ex_valid ignored; async rst_n low mid-cycle clears.
//   6. Preload retired_cnt near 0xFFFF via 65535 NOP commits -> next commit wraps to 0; rst_n asserted in FLUSH -> RUN.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: opcode map, stage state, opcode classifiers.
package wb_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LOAD      = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU_FIRST = 4'h1;
    localparam logic [OPC_W-1:0] OP_ALU_LAST  = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP       = 4'h7;
    localparam logic [OPC_W-1:0] OP_BRN       = 4'h8;
    localparam logic [OPC_W-1:0] OP_BRZ       = 4'h9;
    localparam logic [OPC_W-1:0] OP_HALT      = 4'hF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } wb_state_e;

    // ALU class updates the architectural flags
    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    // Classes that write the register file
    function automatic logic is_write(input logic [OPC_W-1:0] op);
        return (op == OP_LOAD) || is_alu(op);
    endfunction

endpackage

// File: rtl/wb_flush_ctr.sv
// Wrong-path squash counter: load on redirect, count down, done when one cycle remains.
module wb_flush_ctr #(
    parameter int unsigned CYCLES = 2,
    localparam int unsigned CNT_W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(CYCLES);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires execute results, owns N/Z flags, squashes wrong path, halts.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned PC_W         = 12,
    parameter int unsigned RF_AW        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [PC_W-1:0]   ex_operand,
    input  logic [RF_AW-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_n,
    input  logic              ex_z,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_target,
    output logic              flag_n,
    output logic              flag_z,
    output logic              halted,
    output logic [15:0]       retired_cnt
);

    localparam int unsigned CNT_W     = 16;
    localparam bit          SQUASH_EN = (FLUSH_CYCLES != 0);

    wb_state_e state_q, state_d;

    logic              rf_we_q, rf_we_d;
    logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              pc_load_q, pc_load_d;
    logic [PC_W-1:0]   pc_target_q, pc_target_d;
    logic              flag_n_q, flag_n_d;
    logic              flag_z_q, flag_z_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic accept_c, commit_c, taken_c;
    logic ctr_load_c, ctr_dec_c, ctr_done_c;

    assign ex_ready = (state_q != HALT);
    assign accept_c = ex_valid && ex_ready;
    assign commit_c = accept_c && (state_q == RUN);

    // Branch decision uses flags as they stand before this commit
    assign taken_c = commit_c && ((ex_opcode == OP_JMP) ||
                                  ((ex_opcode == OP_BRN) && flag_n_q) ||
                                  ((ex_opcode == OP_BRZ) && flag_z_q));

    wb_flush_ctr #(
        .CYCLES (FLUSH_CYCLES)
    ) u_flush_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ctr_load_c),
        .dec_i  (ctr_dec_c),
        .done_c (ctr_done_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and squash-counter control
    always_comb begin
        state_d    = state_q;
        ctr_load_c = 1'b0;
        ctr_dec_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (commit_c && (ex_opcode == OP_HALT)) begin
                    state_d = HALT;
                end else if (taken_c && SQUASH_EN) begin
                    state_d    = FLUSH;
                    ctr_load_c = 1'b1;
                end
            end
            FLUSH: begin
                ctr_dec_c = 1'b1;
                if (ctr_done_c) begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Commit effects: pulses default low, data and flags hold unless committed
    always_comb begin
        rf_we_d     = 1'b0;
        pc_load_d   = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        pc_target_d = pc_target_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;
        halted_d    = halted_q;
        retired_d   = retired_q;
        if (commit_c) begin
            retired_d = retired_q + CNT_W'(1);
            if (is_write(ex_opcode)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = ex_rd;
                rf_wdata_d = ex_result;
            end
            if (is_alu(ex_opcode)) begin
                flag_n_d = ex_n;
                flag_z_d = ex_z;
            end
            if (taken_c) begin
                pc_load_d   = 1'b1;
                pc_target_d = ex_operand;
            end
            if (ex_opcode == OP_HALT) begin
                halted_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign pc_load     = pc_load_q;
    assign pc_target   = pc_target_q;
    assign flag_n      = flag_n_q;
    assign flag_z      = flag_z_q;
    assign halted      = halted_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: reference model pushes expected outputs per cycle.
module tb_writeback_stage;
    import wb_pkg::*;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned PC_W         = 12;
    localparam int unsigned RF_AW        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic [3:0]        ex_opcode = '0;
    logic [PC_W-1:0]   ex_operand = '0;
    logic [RF_AW-1:0]  ex_rd = '0;
    logic [DATA_W-1:0] ex_result = '0;
    logic              ex_n = 1'b0;
    logic              ex_z = 1'b0;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              pc_load;
    logic [PC_W-1:0]   pc_target;
    logic              flag_n;
    logic              flag_z;
    logic              halted;
    logic [15:0]       retired_cnt;

    writeback_stage #(
        .DATA_W       (DATA_W),
        .PC_W         (PC_W),
        .RF_AW        (RF_AW),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_opcode   (ex_opcode),
        .ex_operand  (ex_operand),
        .ex_rd       (ex_rd),
        .ex_result   (ex_result),
        .ex_n        (ex_n),
        .ex_z        (ex_z),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rf_we;
        logic [RF_AW-1:0]  waddr;
        logic [DATA_W-1:0] wdata;
        logic              pc_load;
        logic [PC_W-1:0]   target;
        logic              fn;
        logic              fz;
        logic              halted;
        logic [15:0]       cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;          // modelled architectural outputs
    int   m_state;    // 0 RUN, 1 FLUSH, 2 HALT
    int   m_fc;       // remaining squash cycles
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check_eq("rf_we",       32'(rf_we),       32'(e.rf_we));
        check_eq("rf_waddr",    32'(rf_waddr),    32'(e.waddr));
        check_eq("rf_wdata",    32'(rf_wdata),    32'(e.wdata));
        check_eq("pc_load",     32'(pc_load),     32'(e.pc_load));
        check_eq("pc_target",   32'(pc_target),   32'(e.target));
        check_eq("flag_n",      32'(flag_n),      32'(e.fn));
        check_eq("flag_z",      32'(flag_z),      32'(e.fz));
        check_eq("halted",      32'(halted),      32'(e.halted));
        check_eq("retired_cnt", 32'(retired_cnt), 32'(e.cnt));
    endtask

    task automatic model_reset();
        m       = '0;
        m_state = 0;
        m_fc    = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge
    task automatic step(input logic v, input logic [3:0] op, input logic [PC_W-1:0] opnd,
                        input logic [RF_AW-1:0] rd, input logic [DATA_W-1:0] res,
                        input logic n, input logic z);
        exp_t e;
        logic acc;
        logic taken;
        ex_valid   = v;
        ex_opcode  = op;
        ex_operand = opnd;
        ex_rd      = rd;
        ex_result  = res;
        ex_n       = n;
        ex_z       = z;
        #1;
        check_eq("ex_ready", 32'(ex_ready), 32'(m_state != 2));
        e         = m;
        e.rf_we   = 1'b0;
        e.pc_load = 1'b0;
        acc       = v && (m_state != 2);
        if (m_state == 1) begin
            m_fc = m_fc - 1;
            if (m_fc == 0) m_state = 0;
        end else if ((m_state == 0) && acc) begin
            e.cnt = m.cnt + 16'd1;
            taken = (op == 4'h7) || ((op == 4'h8) && m.fn) || ((op == 4'h9) && m.fz);
            if (op <= 4'h6) begin
                e.rf_we = 1'b1;
                e.waddr = rd;
                e.wdata = res;
            end
            if ((op >= 4'h1) && (op <= 4'h6)) begin
                e.fn = n;
                e.fz = z;
            end
            if (taken) begin
                e.pc_load = 1'b1;
                e.target  = opnd;
                m_state   = 1;
                m_fc      = FLUSH_CYCLES;
            end
            if (op == 4'hF) begin
                e.halted = 1'b1;
                m_state  = 2;
            end
        end
        m = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            check_outputs(exp_q.pop_front());
        end
    endtask

    task automatic idle();
        step(1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // 1. reset held, then released
        repeat (3) @(posedge clk);
        #1;
        check_outputs(m);
        check_eq("rst_ready", 32'(ex_ready), 32'(1));
        #3 rst_n = 1'b1;
        idle();
        check_eq("rst_rf_we", 32'(rf_we), 32'(0));

        // 2. LOAD
        step(1'b1, OP_LOAD, 12'h000, 4'd3, 16'h0ABC, 1'b1, 1'b1);
        check_eq("t2_we",    32'(rf_we),       32'(1));
        check_eq("t2_waddr", 32'(rf_waddr),    32'(3));
        check_eq("t2_wdata", 32'(rf_wdata),    32'(16'h0ABC));
        check_eq("t2_flagz", 32'(flag_z),      32'(0));
        check_eq("t2_cnt",   32'(retired_cnt), 32'(1));

        // 3. ALU sets Z, back-to-back BRZ taken, two wrong-path ALUs squashed
        step(1'b1, 4'h2, 12'h000, 4'd5, 16'h0000, 1'b0, 1'b1);
        step(1'b1, OP_BRZ, 12'h040, 4'd0, 16'h1111, 1'b0, 1'b0);
        check_eq("t3_pcld",  32'(pc_load),   32'(1));
        check_eq("t3_tgt",   32'(pc_target), 32'(12'h040));
        step(1'b1, 4'h3, 12'h000, 4'd6, 16'h1234, 1'b1, 1'b0);
        check_eq("t3_sq1",   32'(rf_we),     32'(0));
        step(1'b1, 4'h3, 12'h000, 4'd7, 16'h5678, 1'b1, 1'b0);
        check_eq("t3_sq2",   32'(rf_we),     32'(0));
        check_eq("t3_flagz", 32'(flag_z),    32'(1));
        step(1'b1, 4'h3, 12'h000, 4'd8, 16'h9ABC, 1'b0, 1'b0);
        check_eq("t3_c3",    32'(rf_we),     32'(1));
        check_eq("t3_c3d",   32'(rf_wdata),  32'(16'h9ABC));

        // 4. BRN not taken, then JMP to top of address space
        step(1'b1, OP_BRN, 12'h222, 4'd0, 16'h0000, 1'b0, 1'b0);
        check_eq("t4_brn",   32'(pc_load),     32'(0));
        check_eq("t4_cnt",   32'(retired_cnt), 32'(5));
        step(1'b1, 4'h4, 12'h000, 4'd9, 16'h0042, 1'b0, 1'b0);
        check_eq("t4_noflush", 32'(rf_we),     32'(1));
        step(1'b1, OP_JMP, 12'hFFF, 4'd0, 16'h0000, 1'b0, 1'b0);
        check_eq("t4_jmp",   32'(pc_target),   32'(12'hFFF));
        idle();
        idle();

        // random traffic (no HALT)
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)), 12'($urandom),
                 4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();
        idle();

        // 5. HALT, ignored traffic, async reset mid-cycle
        step(1'b1, OP_HALT, 12'h000, 4'd0, 16'h0000, 1'b0, 1'b0);
        check_eq("t5_halt",  32'(halted),   32'(1));
        check_eq("t5_ready", 32'(ex_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h1, 12'h100, 4'd2, 16'hBEEF, 1'b1, 1'b1);
        end
        check_eq("t5_ign",   32'(rf_we),    32'(0));
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(m);
        check_eq("t5_rst_ready", 32'(ex_ready), 32'(1));
        #2 rst_n = 1'b1;

        // 6. retired counter wrap
        for (int i = 0; i < 65535; i++) begin
            step(1'b1, 4'hA, 12'h000, 4'd0, 16'h0000, 1'b0, 1'b0);
        end
        check_eq("t6_ffff", 32'(retired_cnt), 32'(16'hFFFF));
        step(1'b1, 4'hC, 12'h000, 4'd0, 16'h0000, 1'b0, 1'b0);
        check_eq("t6_wrap", 32'(retired_cnt), 32'(0));

        // reset asserted while squashing returns straight to RUN
        step(1'b1, OP_JMP, 12'h123, 4'd0, 16'h0000, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(m);
        #2 rst_n = 1'b1;
        step(1'b1, 4'h5, 12'h000, 4'd4, 16'h7777, 1'b1, 1'b0);
        check_eq("t6_run_we", 32'(rf_we),    32'(1));
        check_eq("t6_run_d",  32'(rf_wdata), 32'(16'h7777));
        check_eq("t6_run_n",  32'(flag_n),   32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
